// File: rtl/fp_add.sv
// fp_add: three-stage IEEE-754 single-precision adder (align | add/sub | normalize/round/pack).
// Define FPA_SUBNORMAL_EN for gradual underflow; by default subnormals flush to signed zero.
module fp_add (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] c,
   input  logic        clk,
   input  logic        rst_n
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // {exponent, significand with hidden bit}; subnormals ride at exponent 1
   function automatic logic [31:0] unpack(input logic [31:0] x);
      if (x[30:23] != 8'd0) unpack = {x[30:23], 1'b1, x[22:0]};
`ifdef FPA_SUBNORMAL_EN
      else unpack = {8'd1, 1'b0, x[22:0]};
`else
      else unpack = '0;
`endif
   endfunction

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      lzc27 = 5'd27;
      for (int i = 0; i <= 26; i++)
         if (v[i]) lzc27 = 5'(26 - i);
   endfunction

   // ---------------- stage 1: unpack, specials, swap, align
   logic [31:0] ua, ub, lg, sm;
   logic        a_big, a_nan, b_nan, a_inf, b_inf;
   logic [7:0]  dexp;
   logic [26:0] sm_ext, sm_sh;
   logic        s1_spec_d, s1_sign_d, s1_sub_d;
   logic [31:0] s1_sval_d;
   logic [7:0]  s1_exp_d;
   logic [26:0] s1_big_d, s1_sml_d;

   always_comb begin
      ua     = unpack(a);
      ub     = unpack(b);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_big  = ua >= ub;
      lg     = a_big ? ua : ub;
      sm     = a_big ? ub : ua;
      s1_sign_d = a_big ? a[31] : b[31];
      s1_sub_d  = a[31] ^ b[31];
      s1_exp_d  = lg[31:24];
      dexp      = lg[31:24] - sm[31:24];
      s1_big_d  = {lg[23:0], 3'b000};
      sm_ext    = {sm[23:0], 3'b000};
      sm_sh     = sm_ext >> dexp;
      // guard/round sit in bits 2:1, bit 0 collects everything shifted past them
      if (dexp >= 8'd26) s1_sml_d = {26'd0, |sm[23:0]};
      else s1_sml_d = {sm_sh[26:1], sm_sh[0] | (|(sm_ext & ((27'd1 << dexp) - 27'd1)))};
      s1_spec_d = 1'b1;
      s1_sval_d = QNAN;
      if (a_nan || b_nan || (a_inf && b_inf && s1_sub_d)) s1_sval_d = QNAN;
      else if (a_inf) s1_sval_d = {a[31], 8'hFF, 23'd0};
      else if (b_inf) s1_sval_d = {b[31], 8'hFF, 23'd0};
      else s1_spec_d = 1'b0;
   end

   logic        s1_spec_q, s1_sign_q, s1_sub_q;
   logic [31:0] s1_sval_q;
   logic [7:0]  s1_exp_q;
   logic [26:0] s1_big_q, s1_sml_q;

   // ---------------- stage 2: add / subtract magnitudes
   logic [27:0] s2_sum_d;
   logic        s2_sign_d;

   always_comb begin
      s2_sum_d  = s1_sub_q ? {1'b0, s1_big_q} - {1'b0, s1_sml_q}
                           : {1'b0, s1_big_q} + {1'b0, s1_sml_q};
      s2_sign_d = (s1_sub_q && s2_sum_d == 28'd0) ? 1'b0 : s1_sign_q;
   end

   logic        s2_spec_q, s2_sign_q;
   logic [31:0] s2_sval_q;
   logic [7:0]  s2_exp_q;
   logic [27:0] s2_sum_q;

   // ---------------- stage 3: normalize, round, pack
   logic        carry, uflow, rnd;
   logic [26:0] x, xn;
   logic [9:0]  e1, sh, e;
   logic [4:0]  lz;
   logic [32:0] word;
   logic [31:0] c_d;

   always_comb begin
      carry = s2_sum_q[27];
      x     = carry ? {s2_sum_q[27:2], |s2_sum_q[1:0]} : s2_sum_q[26:0];
      e1    = {2'b00, s2_exp_q} + 10'(carry);
      lz    = lzc27(x);
`ifdef FPA_SUBNORMAL_EN
      uflow = 1'b0;
      sh    = (10'(lz) > e1 - 10'd1) ? e1 - 10'd1 : 10'(lz);
`else
      uflow = 10'(lz) >= e1;
      sh    = 10'(lz);
`endif
      xn    = x << sh;
      e     = e1 - sh;
      rnd   = xn[2] & ((|xn[1:0]) | xn[3]);
      // hidden bit adds into the exponent field, so denormal round-up and
      // significand overflow both carry into the exponent for free
      word  = {e - 10'd1, 23'd0} + 33'(xn[26:3]) + 33'(rnd);
      if (s2_spec_q) c_d = s2_sval_q;
      else if (s2_sum_q == 28'd0 || uflow) c_d = {s2_sign_q, 31'd0};
      else if (word[32:23] >= 10'd255) c_d = {s2_sign_q, 8'hFF, 23'd0};
      else c_d = {s2_sign_q, word[30:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_spec_q <= 1'b0; s1_sign_q <= 1'b0; s1_sub_q <= 1'b0; s1_sval_q <= '0;
         s1_exp_q  <= '0;   s1_big_q  <= '0;   s1_sml_q <= '0;
         s2_spec_q <= 1'b0; s2_sign_q <= 1'b0; s2_sval_q <= '0;
         s2_exp_q  <= '0;   s2_sum_q  <= '0;
         c         <= '0;
      end else begin
         s1_spec_q <= s1_spec_d; s1_sign_q <= s1_sign_d; s1_sub_q <= s1_sub_d;
         s1_sval_q <= s1_sval_d; s1_exp_q  <= s1_exp_d;  s1_big_q <= s1_big_d;
         s1_sml_q  <= s1_sml_d;
         s2_spec_q <= s1_spec_q; s2_sign_q <= s2_sign_d; s2_sval_q <= s1_sval_q;
         s2_exp_q  <= s1_exp_q;  s2_sum_q  <= s2_sum_d;
         c         <= c_d;
      end
   end
endmodule

// File: tb/tb_fp_add.sv
// Bench for fp_add: directed vector table, randomized ops vs a real-arithmetic model, reset sequences.
module tb_fp_add;
   typedef struct packed { logic [31:0] a; logic [31:0] b; logic [31:0] c; } vec_t;
   typedef struct { logic chk; logic [31:0] exp; string nm; } sb_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a = '0, b = '0, c;
   int          n_chk = 0, n_fail = 0;
   sb_t         sbq[$];
   vec_t        tv[13];

   fp_add dut (.a(a), .b(b), .c(c), .clk(clk), .rst_n(rst_n));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: c=%08h expected %08h", nm, act, req);
      end
   endtask

   // one cycle: retire the op issued three negedges ago, then drive a new one
   task automatic step(input logic [31:0] ai, input logic [31:0] bi, input logic chk,
                       input logic [31:0] req, input string nm);
      sb_t ent;
      @(negedge clk);
      if (sbq.size() == 3) begin
         ent = sbq.pop_front();
         if (ent.chk) check(ent.nm, c, ent.exp);
      end
      a = ai;
      b = bi;
      sbq.push_back('{chk, req, nm});
   endtask

   function automatic real f2r(input logic [31:0] x);
      real v;
      if (x[30:23] == 8'd0) begin
`ifdef FPA_SUBNORMAL_EN
         v = real'(int'(x[22:0])) * $bitstoreal({1'b0, 11'd874, 52'd0});
         return x[31] ? -v : v;
`else
         return 0.0;
`endif
      end
      return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
   endfunction

   // exact-ish sum in double, then rounded to single with ties-to-even
   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      logic xn, yn, xi, yi;
      real s, q, fl;
      logic [63:0] d;
      logic [24:0] m;
      int e;
      xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      if (xn || yn) return QNAN;
      if (xi && yi) return (x[31] == y[31]) ? x : QNAN;
      if (xi) return x;
      if (yi) return y;
      s = f2r(x) + f2r(y);
      if (s == 0.0) return (x[31] && y[31]) ? 32'h8000_0000 : 32'h0;
      d = $realtobits(s);
      e = int'(d[62:52]) - 1023 + 127;
      if (e >= 1) begin
         m = {2'b01, d[51:29]};
         if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
         if (m[24]) begin m = m >> 1; e++; end
         if (e >= 255) return {d[63], 8'hFF, 23'd0};
         return {d[63], 8'(e), m[22:0]};
      end
`ifdef FPA_SUBNORMAL_EN
      q  = (s < 0.0 ? -s : s) * $bitstoreal({1'b0, 11'd1172, 52'd0});
      fl = $floor(q);
      if ((q - fl > 0.5) || ((q - fl == 0.5) && (longint'(fl) % 2 == 1))) fl = fl + 1.0;
      return {d[63], 31'(longint'(fl))};
`else
      return {d[63], 31'd0};
`endif
   endfunction

   initial begin
      logic [31:0] x, y, uf_exp;
      int e;
`ifdef FPA_SUBNORMAL_EN
      uf_exp = 32'h0000_0001;
`else
      uf_exp = 32'h0000_0000;
`endif
      tv[0]  = {32'h6BF3A0C3, 32'h6B8E5F1C, 32'h6C40FFF0};
      tv[1]  = {32'h3F980000, 32'h3F100000, 32'h3FE00000};
      tv[2]  = {32'h3F800000, 32'hBF800000, 32'h00000000};
      tv[3]  = {32'h40400000, 32'hBF800000, 32'h40000000};
      tv[4]  = {32'h7F800000, 32'hFF800000, 32'h7FC00000};
      tv[5]  = {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
      tv[6]  = {32'h7FC00001, 32'h3F800000, 32'h7FC00000};
      tv[7]  = {32'h00800001, 32'h80800000, uf_exp};
      tv[8]  = {32'h80000000, 32'h80000000, 32'h80000000};
      tv[9]  = {32'h00000000, 32'h80000000, 32'h00000000};
      tv[10] = {32'h7F800000, 32'h3F800000, 32'h7F800000};
      tv[11] = {32'h40A00000, 32'hFF800000, 32'hFF800000};
      tv[12] = {32'hBF800000, 32'h33000000, 32'hBF800000};

      rst_n = 1'b0;
      a = 32'h3F80_0000;
      b = 32'h3F80_0000;
      #12 check("reset_state", c, 32'h0);
      @(negedge clk);
      check("reset_hold", c, 32'h0);
      rst_n = 1'b1;
      a = '0;
      b = '0;
      repeat (3) sbq.push_back('{1'b1, 32'h0, "zero_pipe"});

      foreach (tv[i]) step(tv[i].a, tv[i].b, 1'b1, tv[i].c, $sformatf("vec%0d", i));

      for (int i = 0; i < 400; i++) begin
         x = $urandom();
         y = $urandom();
         case ($urandom_range(0, 4))
            1: begin
               e = int'(x[30:23]) + int'($urandom_range(0, 6)) - 3;
               if (e < 0) e = 0;
               if (e > 254) e = 254;
               y[30:23] = 8'(e);
            end
            2: y = {~x[31], x[30:4], y[3:0]};
            3: begin
               x[30:23] = 8'($urandom_range(0, 2));
               y[30:23] = 8'($urandom_range(0, 2));
               y[31]    = ~x[31];
            end
            4: begin
               x[30:23] = 8'($urandom_range(250, 254));
               y[30:23] = 8'($urandom_range(250, 254));
               y[31]    = x[31];
            end
            default: ;
         endcase
         step(x, y, 1'b1, ref_add(x, y), $sformatf("rand%0d[%08h+%08h]", i, x, y));
      end
      repeat (3) step($urandom(), $urandom(), 1'b0, 32'h0, "fill");

      // pipe is full of random ops; drop reset between edges
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst_mid_async", c, 32'h0);
      sbq.delete();
      @(posedge clk);
      #1 check("rst_mid_hold", c, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      a = 32'h3F80_0000;
      b = 32'h3F80_0000;
      @(negedge clk);
      check("rst_rel_edge1", c, 32'h0);
      a = '0;
      b = '0;
      @(negedge clk);
      check("rst_rel_edge2", c, 32'h0);
      @(negedge clk);
      check("rst_rel_one_plus_one", c, 32'h4000_0000);
      @(negedge clk);
      check("rst_rel_zero_follow", c, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_add.md
# fp_add

Pipelined IEEE-754 single-precision floating-point adder. It accepts two 32-bit operands every clock and produces their rounded sum a fixed three cycles later. It sits in the datapath as the add/subtract-magnitude unit: signed operands are handled, so opposite signs perform an effective subtraction. The block has no handshake; every cycle carries a valid operation.

## Interface
- No parameters. Format is fixed: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.
- Positional port order is a, b, c, clk, rst_n.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- a  input  32  operand A, IEEE-754 single.
- b  input  32  operand B, IEEE-754 single.
- c  output  32  registered result, c = round(a + b).

## Operation
- **Stage 1: unpack/align**
  - Extract sign, exponent and fraction, with the hidden 1 for normals.
  - Swap the operands so the larger magnitude is first; compare by exponent, then by fraction.
  - Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits.
  - Shifts of 26 or more leave only the sticky bit.
- **Stage 2: add/sub**
  - Same signs: add significands (25-bit result).
  - Opposite signs: subtract the smaller from the larger.
  - Result sign is the sign of the larger-magnitude operand.
- **Stage 3: normalize/round/pack**
  - On carry-out: shift right 1 and increment the exponent.
  - Otherwise: left-shift by the leading-zero count and decrement the exponent.
  - Round to nearest, ties to even.
  - If rounding overflows the significand, renormalize.
- **Special cases** (decided in stage 1, carried through the pipe):
  - Either operand NaN → output 0x7FC00000.
  - +Inf + −Inf → 0x7FC00000.
  - Inf + finite → that Inf.
  - Exponent reaching 255 after rounding → ±Inf (0x7F800000 / 0xFF800000).
  - Exact zero result from opposite signs → +0 (0x00000000).
  - −0 + −0 → 0x80000000.
- **Exponent underflow** during normalization is handled per Configuration.

## Timing
- Latency is 3 rising edges: operands sampled at edge N appear on c after edge N+2 and are stable until edge N+3.
- Throughput is one operation per cycle; back-to-back operand changes every cycle are legal.
- Reset (rst_n=0) asynchronously clears all pipeline registers, so c = 0x00000000 immediately and while rst_n is held low.
- After rst_n rises, the first valid result appears 3 edges after the first sampled operands. Until then c shows the sum of the zeroed pipeline contents, which is 0x00000000.
- Reset asserted mid-operation discards all in-flight results; no partial outputs are produced.
- a and b are not registered until stage 1; they must meet setup to clk.

## Configuration
- Macro: FPA_SUBNORMAL_EN.
- **Defined:**
  - Subnormal inputs (exp=0, fraction≠0) are treated as 0.fraction × 2^−126.
  - Results below the normal range are denormalized by right-shifting into exponent 0, with correct round-to-nearest-even.
  - Gradual underflow to ±0.
- **Undefined (default):**
  - Subnormal inputs are flushed to signed zero before alignment.
  - Any result whose exponent would fall below 1 is flushed to signed zero (sign of the larger operand; +0 for an exact cancel).
  - Normalized-range results are identical in both builds.

## Test plan
- **Equal-exponent add with carry and tie round-to-even:** a=0x6BF3A0C3, b=0x6B8E5F1C → c=0x6C40FFF0 three edges later.
- **Different exponents, exact:** a=0x3F980000 (1.1875), b=0x3F100000 (0.5625) → c=0x3FE00000 (1.75). Apply it one cycle after the previous vector; both results emerge on consecutive cycles.
- **Cancellation and sign:**
  - a=0x3F800000, b=0xBF800000 → c=0x00000000.
  - a=0x40400000 (3.0), b=0xBF800000 (−1.0) → c=0x40000000.
- **Specials:**
  - a=0x7F800000, b=0xFF800000 → 0x7FC00000.
  - a=0x7F7FFFFF, b=0x7F7FFFFF → 0x7F800000.
  - a=0x7FC00001, b=0x3F800000 → 0x7FC00000.
- **Underflow:** a=0x00800001, b=0x80800000.
  - With FPA_SUBNORMAL_EN defined → c=0x00000001.
  - Without it → c=0x00000000.
- **Async reset mid-stream:** drive rst_n low between edges while the pipe is full → c=0x00000000 immediately. Release it, apply a=0x3F800000, b=0x3F800000 → c=0x40000000 after 3 edges.
